power_domain_sequencer: RTL and testbench

- Sequences power-switch, isolation, retention save/restore and domain reset for every power domain, in the order required by the library.
- Domain-enable requests come from the power-domain control logic. The block arbitrates round-robin among domains whose request differs from their current state and runs one transition at a time, which bounds in-rush current.
- It sits between the power-state controller and the physical power switches and isolation cells.

---
 rtl/power_pkg.sv | 25 ++
 rtl/power_rr_arbiter.sv | 44 ++++
 rtl/power_domain_sequencer.sv | 169 ++++++++++++++++
 tb/tb_power_domain_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/power_pkg.sv
// rtl/power_pkg.sv - shared types and constants for the power-domain sequencer
package power_pkg;

  localparam logic [7:0] PWR_SEQ_DEFAULT_SETTLE = 8'd4;
  localparam int unsigned PWR_SEQ_IDX_W = 3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ISO_ON,
    S_SAVE,
    S_RST_ASSERT,
    S_PWR_OFF,
    S_PWR_ON,
    S_RESTORE,
    S_RST_REL,
    S_ISO_OFF
  } pwr_seq_state_t;

  typedef struct packed {
    logic                     busy;
    logic [PWR_SEQ_IDX_W-1:0] active_domain;
    logic [31:0]              seq_count;
  } pwr_seq_status_t;

endpackage

// File: rtl/power_rr_arbiter.sv
// rtl/power_rr_arbiter.sv - round-robin pick among pending domains with a registered pointer
module power_rr_arbiter #(
  parameter  int N = 5,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_req,
  input  logic         i_advance,
  output logic [W-1:0] o_grant_idx,
  output logic         o_grant_valid
);

  logic [W-1:0] r_ptr;
  logic [W-1:0] w_cand;
  int           w_sum;

  // first requesting index at or after the pointer; lowest offset wins
  always_comb begin
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_cand        = '0;
    w_sum         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = int'(r_ptr) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_cand = W'(w_sum);
      if (i_req[w_cand]) begin
        o_grant_idx   = w_cand;
        o_grant_valid = 1'b1;
      end
    end
  end

  // pointer moves just past the granted domain when a grant is taken
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_advance && o_grant_valid) begin
      r_ptr <= (o_grant_idx == W'(N - 1)) ? '0 : o_grant_idx + W'(1);
    end
  end

endmodule

// File: rtl/power_domain_sequencer.sv
// rtl/power_domain_sequencer.sv - one-at-a-time power up/down sequencing of domains
module power_domain_sequencer
  import power_pkg::*;
#(
  parameter  int NUM_DOMAINS      = 5,
  parameter  int SETTLE_W         = 8,
  parameter  int ISO_SETUP_CYCLES = 2,
  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_DOMAINS-1:0] domain_en_req_i,
  input  logic [NUM_DOMAINS-1:0] retention_req_i,
  input  logic [SETTLE_W-1:0]    settle_cycles_i,
  output logic [NUM_DOMAINS-1:0] pwr_switch_o,
  output logic [NUM_DOMAINS-1:0] iso_en_o,
  output logic [NUM_DOMAINS-1:0] ret_save_o,
  output logic [NUM_DOMAINS-1:0] ret_restore_o,
  output logic [NUM_DOMAINS-1:0] domain_rst_no,
  output logic [NUM_DOMAINS-1:0] domain_on_o,
  output logic                   busy_o,
  output logic [IDX_W-1:0]       active_domain_o,
  output logic [31:0]            seq_count_o
);

  localparam int ISO_W = $clog2(ISO_SETUP_CYCLES + 1);
  localparam int CNT_W = (SETTLE_W > ISO_W) ? SETTLE_W : ISO_W;

  pwr_seq_state_t         r_state;
  logic [NUM_DOMAINS-1:0] r_pwr_switch, r_iso, r_save, r_restore, r_rst_n, r_on, r_retained;
  logic                   r_busy, r_ret;
  logic [IDX_W-1:0]       r_active;
  logic [31:0]            r_count;
  logic [SETTLE_W-1:0]    r_settle;
  logic [CNT_W-1:0]       r_cnt;

  logic [NUM_DOMAINS-1:0] w_pending;
  logic [IDX_W-1:0]       w_grant_idx;
  logic                   w_grant_valid;
  logic                   w_advance;
  logic [SETTLE_W-1:0]    w_settle;

  assign w_pending = domain_en_req_i ^ r_on;
  assign w_advance = (r_state == S_IDLE);
  assign w_settle  = (settle_cycles_i == '0) ? SETTLE_W'(1) : settle_cycles_i;

  power_rr_arbiter #(.N(NUM_DOMAINS)) u_arb (
    .i_clk         (clk_i),
    .i_rst_n       (rst_ni),
    .i_req         (w_pending),
    .i_advance     (w_advance),
    .o_grant_idx   (w_grant_idx),
    .o_grant_valid (w_grant_valid)
  );

  assign pwr_switch_o    = r_pwr_switch;
  assign iso_en_o        = r_iso;
  assign ret_save_o      = r_save;
  assign ret_restore_o   = r_restore;
  assign domain_rst_no   = r_rst_n;
  assign domain_on_o     = r_on;
  assign busy_o          = r_busy;
  assign active_domain_o = r_active;
  assign seq_count_o     = r_count;

  // sequencer FSM: only the active domain's controls change in any state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_pwr_switch <= '1;
      r_iso        <= '0;
      r_save       <= '0;
      r_restore    <= '0;
      r_rst_n      <= '1;
      r_on         <= '1;
      r_retained   <= '0;
      r_busy       <= 1'b0;
      r_ret        <= 1'b0;
      r_active     <= '0;
      r_count      <= '0;
      r_settle     <= '0;
      r_cnt        <= '0;
    end else begin
      r_save    <= '0;
      r_restore <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_valid) begin
            r_active <= w_grant_idx;
            r_busy   <= 1'b1;
            r_settle <= w_settle;
            if (r_on[w_grant_idx]) begin
              r_ret               <= retention_req_i[w_grant_idx];
              r_iso[w_grant_idx]  <= 1'b1;
              r_cnt               <= CNT_W'(ISO_SETUP_CYCLES);
              r_state             <= S_ISO_ON;
            end else begin
              r_ret                     <= 1'b0;
              r_pwr_switch[w_grant_idx] <= 1'b1;
              r_cnt                     <= CNT_W'(w_settle);
              r_state                   <= S_PWR_ON;
            end
          end
        end
        S_ISO_ON: begin
          if (r_cnt == CNT_W'(1)) begin
            if (r_ret) begin
              r_save[r_active]     <= 1'b1;
              r_retained[r_active] <= 1'b1;
              r_state              <= S_SAVE;
            end else begin
              r_rst_n[r_active] <= 1'b0;
              r_state           <= S_RST_ASSERT;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_SAVE: begin
          r_rst_n[r_active] <= 1'b0;
          r_state           <= S_RST_ASSERT;
        end
        S_RST_ASSERT: begin
          r_pwr_switch[r_active] <= 1'b0;
          r_cnt                  <= CNT_W'(r_settle);
          r_state                <= S_PWR_OFF;
        end
        S_PWR_OFF: begin
          if (r_cnt == CNT_W'(1)) begin
            r_on[r_active] <= 1'b0;
            r_count        <= r_count + 32'd1;
            r_busy         <= 1'b0;
            r_state        <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_PWR_ON: begin
          if (r_cnt == CNT_W'(1)) begin
            if (r_retained[r_active]) begin
              r_restore[r_active]  <= 1'b1;
              r_retained[r_active] <= 1'b0;
              r_state              <= S_RESTORE;
            end else begin
              r_rst_n[r_active] <= 1'b1;
              r_state           <= S_RST_REL;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESTORE: begin
          r_rst_n[r_active] <= 1'b1;
          r_state           <= S_RST_REL;
        end
        S_RST_REL: begin
          r_iso[r_active] <= 1'b0;
          r_on[r_active]  <= 1'b1;
          r_count         <= r_count + 32'd1;
          r_busy          <= 1'b0;
          r_state         <= S_ISO_OFF;
        end
        S_ISO_OFF: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_power_domain_sequencer.sv
// tb/tb_power_domain_sequencer.sv - self-checking bench with an event-timeline reference model
module tb_power_domain_sequencer;
  localparam int N   = 5;
  localparam int ISO = 2;
  localparam int SW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req, ret;
  logic [SW-1:0] settle;
  logic [N-1:0]  pwr_switch_o, iso_en_o, ret_save_o, ret_restore_o, domain_rst_no, domain_on_o;
  logic          busy_o;
  logic [2:0]    active_domain_o;
  logic [31:0]   seq_count_o;

  always #5 clk = ~clk;

  power_domain_sequencer #(.NUM_DOMAINS(N), .SETTLE_W(SW), .ISO_SETUP_CYCLES(ISO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .domain_en_req_i(req), .retention_req_i(ret),
    .settle_cycles_i(settle), .pwr_switch_o(pwr_switch_o), .iso_en_o(iso_en_o),
    .ret_save_o(ret_save_o), .ret_restore_o(ret_restore_o), .domain_rst_no(domain_rst_no),
    .domain_on_o(domain_on_o), .busy_o(busy_o), .active_domain_o(active_domain_o),
    .seq_count_o(seq_count_o)
  );

  int n_pass = 0;
  int n_total = 0;

  // reference model: expected output values plus the timeline of the running transition
  logic [N-1:0] m_on, m_sw, m_iso, m_rstn, m_save, m_rest, m_flag;
  bit           m_busy, m_down, m_ret;
  int           m_active, m_ptr, m_d, m_s, m_er, m_ep, m_ed;
  logic [31:0]  m_count;
  longint       t, g, next_ok;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_on = '1; m_sw = '1; m_rstn = '1; m_iso = '0; m_save = '0; m_rest = '0; m_flag = '0;
    m_busy = 0; m_active = 0; m_ptr = 0; m_count = '0; t = 0; g = 0; next_ok = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] pend;
    bit           found;
    longint       e;
    t++;
    m_save = '0;
    m_rest = '0;
    if (!m_busy && t >= next_ok) begin
      pend  = req ^ m_on;
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && pend[(m_ptr + k) % N]) begin
          m_d   = (m_ptr + k) % N;
          found = 1;
        end
      end
      if (found) begin
        m_ptr    = (m_d + 1) % N;
        m_busy   = 1;
        m_active = m_d;
        g        = t;
        m_down   = m_on[m_d];
        m_s      = (settle == 0) ? 1 : int'(settle);
        if (m_down) begin
          m_ret = ret[m_d];
          m_er  = 1 + ISO + int'(m_ret);
          m_ep  = m_er + 1;
          m_ed  = m_ep + m_s;
        end else begin
          m_ret = m_flag[m_d];
          m_er  = 1 + m_s + int'(m_ret);
          m_ed  = m_er + 1;
        end
      end
    end
    if (m_busy) begin
      e = t - g + 1;
      if (m_down) begin
        if (e == 1) m_iso[m_d] = 1'b1;
        if (m_ret && e == 1 + ISO) m_save[m_d] = 1'b1;
        if (e == m_er) m_rstn[m_d] = 1'b0;
        if (e == m_ep) m_sw[m_d] = 1'b0;
        if (e == m_ed) begin
          m_on[m_d] = 1'b0;
          if (m_ret) m_flag[m_d] = 1'b1;
          m_busy = 0; m_count++; next_ok = t + 1;
        end
      end else begin
        if (e == 1) m_sw[m_d] = 1'b1;
        if (m_ret && e == 1 + m_s) m_rest[m_d] = 1'b1;
        if (e == m_er) m_rstn[m_d] = 1'b1;
        if (e == m_ed) begin
          m_iso[m_d] = 1'b0; m_on[m_d] = 1'b1; m_flag[m_d] = 1'b0;
          m_busy = 0; m_count++; next_ok = t + 2;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("pwr_switch", pwr_switch_o, m_sw);
    chk("iso_en", iso_en_o, m_iso);
    chk("ret_save", ret_save_o, m_save);
    chk("ret_restore", ret_restore_o, m_rest);
    chk("domain_rst_n", domain_rst_no, m_rstn);
    chk("domain_on", domain_on_o, m_on);
    chk("busy", busy_o, m_busy);
    chk("seq_count", seq_count_o, m_count);
    if (m_busy) chk("active_domain", active_domain_o, m_active);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int     order[$];
    bit     prev_busy, saw_save, done;
    int     off_cnt, b;

    rst_n = 1'b0; req = '1; ret = '0; settle = 8'd4;
    model_reset();
    #12;
    check_all();
    chk("reset_switch", pwr_switch_o, 5'h1f);
    chk("reset_on", domain_on_o, 5'h1f);
    rst_n = 1'b1;

    // quiet after reset: nothing pending
    for (int i = 0; i < 10; i++) step();
    chk("quiet_count", seq_count_o, 0);

    // domain 0 down with retention, settle 4
    req[0] = 1'b0; ret[0] = 1'b1; settle = 8'd4;
    for (int e = 1; e <= 9; e++) begin
      step();
      if (e == 1) chk("dn_iso_e1", iso_en_o[0], 1);
      if (e == 3) chk("dn_save_e3", ret_save_o[0], 1);
      if (e == 4) chk("dn_rstn_e4", domain_rst_no[0], 0);
      if (e == 5) chk("dn_sw_e5", pwr_switch_o[0], 0);
      if (e == 8) chk("dn_on_e8", domain_on_o[0], 1);
      if (e == 9) chk("dn_on_e9", domain_on_o[0], 0);
    end
    chk("dn_count", seq_count_o, 1);
    ret[0] = 1'b0;

    // domain 0 back up, restore expected
    req[0] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 1) chk("up_sw_e1", pwr_switch_o[0], 1);
      if (e == 5) chk("up_restore_e5", ret_restore_o[0], 1);
      if (e == 6) chk("up_rstn_e6", domain_rst_no[0], 1);
      if (e == 7) chk("up_on_e7", domain_on_o[0], 1);
      if (e == 7) chk("up_iso_e7", iso_en_o[0], 0);
    end
    chk("up_count", seq_count_o, 2);

    // domains 1..3 dropped together: strict round-robin order
    req[3:1] = 3'b000;
    prev_busy = 0; done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      if (busy_o && !prev_busy) order.push_back(int'(active_domain_o));
      prev_busy = busy_o;
      if (!busy_o && seq_count_o == 32'd5) done = 1;
    end
    chk("rr_timeout", done, 1);
    chk("rr_len", order.size(), 3);
    for (int i = 0; i < order.size() && i < 3; i++) chk("rr_order", order[i], i + 1);

    // settle 0 on domain 4, no retention
    settle = 8'd0; req[4] = 1'b0; ret[4] = 1'b0;
    saw_save = 0; off_cnt = 0; done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      step();
      if (ret_save_o[4]) saw_save = 1;
      if (!pwr_switch_o[4] && domain_on_o[4]) off_cnt++;
      if (!domain_on_o[4]) done = 1;
    end
    chk("s0_timeout", done, 1);
    chk("s0_no_save", saw_save, 0);
    chk("s0_off_cycles", off_cnt, 1);

    // domain 2 up, then reset in the middle of its power-down settle
    settle = 8'd4; req[2] = 1'b1; done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      step();
      if (domain_on_o[2] && !busy_o) done = 1;
    end
    chk("d2_up_timeout", done, 1);
    settle = 8'd30; req[2] = 1'b0; done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      step();
      if (!pwr_switch_o[2]) done = 1;
    end
    chk("d2_pwroff_timeout", done, 1);
    for (int i = 0; i < 3; i++) step();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_switch", pwr_switch_o, 5'h1f);
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    settle = 8'd3; done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      if (!domain_on_o[2]) done = 1;
    end
    chk("d2_resequence", done, 1);
    chk("d2_count", seq_count_o, 2);

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        b = $urandom_range(0, N - 1);
        req[b] = ~req[b];
      end
      ret    = N'($urandom());
      settle = SW'($urandom_range(0, 6));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
